bus_regfile: RTL
================

Name: bus_regfile

Overview:
- Responder end of the CPU register bus (DA/DOUT/DIN/RD/WR); replaces the sixteen 1-bit RAM primitives with one synchronous-reset-free, async-cleared 16x16 register file.
- Serves zero-latency reads and tick-qualified writes, flags protocol violations and counts accepted writes.
- Includes a dump sequencer that walks all registers onto the 8 board LEDs for on-hardware inspection of program results.

Parameters:
- ADDR_W, 4, register index width (16 entries).
- DATA_W, 16, register width.
- HOLD_TICKS, 3, number of en ticks each register stays on the LEDs during a dump (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  one-cycle tick strobe from the clock divider (clk2); qualifies writes and dump pacing.
- DA  in  16  bus address from the CPU; only DA[ADDR_W-1:0] selects a register.
- DOUT  in  16  write data from the CPU.
- DIN  out  16  read data to the CPU.
- RD  in  1  CPU read phase.
- WR  in  1  CPU write phase.
- dump_req  in  1  start an LED dump, sampled on an en tick.
- dump_busy  out  1  high while a dump is in progress.
- led  out  8  {index[3:0], data[3:0]} of the register shown.
- wr_count  out  8  saturating count of accepted writes.
- bus_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n=0): all 16 registers = 0, DIN follows array (0), dump_busy=0, led=0, wr_count=0, bus_err=0, FSM IDLE, index=0, hold counter=0. Reset mid-dump aborts it and clears memory.
- Read: combinational, DIN = mem[DA[3:0]] whenever DA[15:4]==0, independent of RD and en; otherwise DIN=0. Same-cycle write to the read address: DIN shows the old value until the next clk edge.
- Write: on posedge clk when en && WR && !RD && DA[15:4]==0, mem[DA[3:0]] <= DOUT. Writes while en=0 are ignored (the CPU holds WR across a whole tick period; exactly one write per tick).
- Protocol errors, evaluated only on en ticks: RD && WR both high, or (RD||WR) with DA[15:4]!=0. On error no write happens and bus_err sets; bus_err clears only on reset.
- wr_count: +1 per accepted write, saturates at 255.
- Dump FSM, advances only on en ticks:
  - IDLE: led=0, dump_busy=0. If dump_req is high on an en tick, go to SHOW with index=0 and hold=0; dump_busy=1 from the next cycle.
  - SHOW: led = {index, mem[index][3:0]}, live (a bus write to the shown register updates led next cycle). hold increments each tick. When hold==HOLD_TICKS-1 on a tick: hold<=0; if index==15 go to IDLE, else index<=index+1.
  - Total dump length: 16*HOLD_TICKS ticks. dump_req while busy is ignored; a request held high at the end restarts the dump on the next tick.
- Bus access is fully independent of the dump; there is no stall.

Decomposition:
- Shared package cpu_pkg: ADDR_W, DATA_W, opcode constants (OP_ADDI=0, OP_ADD=1, OP_SUB=4, OP_AND=5, OP_OR=6, OP_XOR=7, OP_LD=8, OP_ST=9, OP_HALT=10, OP_JMP=15) and the dump-state enum {IDLE, SHOW}.
- One sub-module: led_dump_seq (FSM, index and hold counters), which reads the array through an index/data port pair. The storage and bus logic stay in bus_regfile.

Test Plan:
- Reset, then drive DA=3 with RD=1: expect DIN=0, led=0, wr_count=0, bus_err=0.
- WR=1, DA=5, DOUT=16'h00A5 held for 3 clks with en high on 1 of them: mem[5]=00A5, wr_count=1. Read DA=5 gives DIN=00A5. The same pattern with en=0 throughout gives no write.
- Write DA=2 with DOUT=7 on a tick and read DA=2 in the same cycle: DIN=old value 0, then 7 the cycle after. Next, RD=WR=1 on a tick: no write and bus_err=1 (sticky). DA=16'h0013 with WR=1: no write, DIN=0.
- Preload regs 0..15 = i+1, HOLD_TICKS=3, pulse dump_req on a tick: led sequence {0,1},{1,2},...,{15,0} (16 & 4'hF), each for 3 ticks. dump_busy stays high for 48 ticks, then led=0.
- Drop rst_n mid-dump at index 7: dump_busy and led go to 0 immediately, all registers read 0, and wr_count=0.
- Issue 300 accepted writes: wr_count stops at 255.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, opcode encodings and the
// LED dump sequencer state type.
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADDI = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } dump_state_e;

endpackage

// File: rtl/led_dump_seq.sv
// Walks every register onto the LEDs, holding each for HOLD_TICKS en ticks.
// The register contents arrive through the index/nibble port pair.
module led_dump_seq
    import cpu_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int HOLD_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dump_req,
    input  logic [3:0]       nibble,
    output logic [IDX_W-1:0] index,
    output logic [7:0]       led,
    output dump_state_e      state
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

    dump_state_e      state_n;
    logic [IDX_W-1:0] index_n;
    logic [7:0]       hold, hold_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            index <= '0;
            hold  <= '0;
        end else begin
            state <= state_n;
            index <= index_n;
            hold  <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        index_n = index;
        hold_n  = hold;
        case (state)
            IDLE: begin
                if (en && dump_req) begin
                    state_n = SHOW;
                    index_n = '0;
                    hold_n  = '0;
                end
            end
            SHOW: begin
                if (en) begin
                    if (hold == HOLD_LAST) begin
                        hold_n = '0;
                        if (index == '1) begin
                            state_n = IDLE;
                            index_n = '0;
                        end else begin
                            index_n = index + IDX_W'(1);
                        end
                    end else begin
                        hold_n = hold + 8'd1;
                    end
                end
            end
        endcase
    end

    // Data nibble is taken live from the array, so a write shows up next cycle.
    assign led = (state == SHOW) ? {index, nibble} : 8'h00;

endmodule

// File: rtl/bus_regfile.sv
// CPU register-bus responder: 16x16 register file with zero-latency reads,
// tick-qualified writes, sticky protocol error flag, write counter and LED dump.
module bus_regfile
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int HOLD_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [15:0]       DA,
    input  logic [DATA_W-1:0] DOUT,
    output logic [DATA_W-1:0] DIN,
    input  logic              RD,
    input  logic              WR,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic [7:0]        led,
    output logic [7:0]        wr_count,
    output logic              bus_err
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              addr_ok;
    logic [ADDR_W-1:0] addr;
    logic              wr_ok;
    logic              fault;
    logic [ADDR_W-1:0] dump_index;
    dump_state_e       dump_state;

    assign addr    = DA[ADDR_W-1:0];
    assign addr_ok = (DA[15:ADDR_W] == '0);
    assign wr_ok   = en && WR && !RD && addr_ok;
    // Violations only count on ticks, where the CPU phase signals are settled.
    assign fault   = en && ((RD && WR) || ((RD || WR) && !addr_ok));

    assign DIN = addr_ok ? mem[addr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[addr] <= DOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (wr_ok && wr_count != 8'hFF) begin
                wr_count <= wr_count + 8'd1;
            end
            if (fault) begin
                bus_err <= 1'b1;
            end
        end
    end

    led_dump_seq #(
        .IDX_W      (ADDR_W),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_dump (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dump_req (dump_req),
        .nibble   (mem[dump_index][3:0]),
        .index    (dump_index),
        .led      (led),
        .state    (dump_state)
    );

    assign dump_busy = (dump_state == SHOW);

endmodule
